// File: rtl/bw_io_impctl_updn_cal.sv
// rtl/bw_io_impctl_updn_cal.sv - impedance up/down calibration engine (optional tracking: IMPCTL_TRACK_EN)
module bw_io_impctl_updn_cal #(
    parameter int CODE_W = 8,
    parameter int FILT_N = 4,
    parameter int LOCK_CNT = 3,
    parameter logic [CODE_W-1:0] INIT_CODE = {1'b1, {(CODE_W-1){1'b0}}}
) (
    input  logic              clk,
    input  logic              global_reset_n,
    input  logic              start,
    input  logic              sclk,
    input  logic              above,
    input  logic              freeze,
    input  logic              upd_ack,
    output logic [CODE_W-1:0] cbd,
    output logic              upd_valid,
    output logic [CODE_W-1:0] upd_code,
    output logic              locked,
    output logic              busy,
    output logic              sat
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCKED} state_t;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DN   = 2'd2;

    state_t              state;
    state_t              state_nxt;
    logic [CODE_W-1:0]   code;
    logic [FILT_N-1:0]   hist;
    logic [3:0]          fill;
    logic                pend;
    logic                pend_up;
    logic [3:0]          rev_cnt;
    logic [1:0]          last_dir;

    logic                filt_en;
    logic [FILT_N:0]     hist_ext;
    logic [FILT_N-1:0]   hist_shift;
    logic [3:0]          fill_inc;
    logic                filt_full;
    logic                filt_unan;
    logic                decide;
    logic                clip;
    logic [CODE_W-1:0]   code_step;
    logic [1:0]          dir_new;
    logic [3:0]          rev_step;
    logic                lock_hit;
    logic                track_step;

    assign busy = (state == ST_SEARCH);

    // Filter qualification, unanimity detection and step arithmetic
    always_comb begin
        filt_en    = 1'b0;
        track_step = 1'b0;
`ifdef IMPCTL_TRACK_EN
        filt_en    = (state == ST_SEARCH || state == ST_LOCKED) && sclk && !freeze && !start;
        track_step = pend && (state == ST_LOCKED);
`else
        filt_en    = (state == ST_SEARCH) && sclk && !freeze && !start;
`endif
        hist_ext   = {hist, above};
        hist_shift = hist_ext[FILT_N-1:0];
        fill_inc   = fill + 4'd1;
        filt_full  = (fill_inc == 4'(FILT_N));
        filt_unan  = (hist_shift == '0) || (hist_shift == '1);
        decide     = filt_en && filt_full && filt_unan;

        clip      = pend_up ? (code == '1) : (code == '0);
        code_step = code;
        if (!clip) begin
            code_step = pend_up ? code + 1'b1 : code - 1'b1;
        end
        dir_new = pend_up ? DIR_UP : DIR_DN;
        // A clipped step may clear the count but never advances it
        rev_step = 4'd0;
        if (last_dir != DIR_NONE && last_dir != dir_new) begin
            rev_step = clip ? rev_cnt : rev_cnt + 4'd1;
        end
        lock_hit = pend && (state == ST_SEARCH) && (rev_step == 4'(LOCK_CNT));
    end

    // FSM state register
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: start always restarts the search
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_SEARCH;
        end else begin
            case (state)
                ST_SEARCH: if (lock_hit) state_nxt = ST_LOCKED;
                default:   state_nxt = state;
            endcase
        end
    end

    // Datapath: filter history, code stepping, lock and update handshake
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            code      <= INIT_CODE;
            cbd       <= INIT_CODE;
            upd_code  <= INIT_CODE;
            upd_valid <= 1'b0;
            locked    <= 1'b0;
            sat       <= 1'b0;
            hist      <= '0;
            fill      <= 4'd0;
            pend      <= 1'b0;
            pend_up   <= 1'b0;
            rev_cnt   <= 4'd0;
            last_dir  <= DIR_NONE;
        end else if (start) begin
            code      <= INIT_CODE;
            upd_valid <= 1'b0;
            locked    <= 1'b0;
            sat       <= 1'b0;
            hist      <= '0;
            fill      <= 4'd0;
            pend      <= 1'b0;
            rev_cnt   <= 4'd0;
            last_dir  <= DIR_NONE;
        end else begin
            if (upd_valid && upd_ack) begin
                cbd       <= upd_code;
                upd_valid <= 1'b0;
            end

            pend <= 1'b0;
            if (filt_en) begin
                if (decide) begin
                    hist    <= '0;
                    fill    <= 4'd0;
                    pend    <= 1'b1;
                    pend_up <= above;
                end else if (filt_full) begin
                    // Mixed window: forget the oldest sample and keep collecting
                    hist <= hist_shift;
                    fill <= 4'(FILT_N - 1);
                end else begin
                    hist <= hist_shift;
                    fill <= fill_inc;
                end
            end

            if (pend) begin
                code     <= code_step;
                last_dir <= dir_new;
                if (clip) begin
                    sat <= 1'b1;
                end
                if (state == ST_SEARCH) begin
                    rev_cnt <= rev_step;
                end
            end

            // Lock offer is made even if freeze rose this cycle
            if (lock_hit) begin
                locked    <= 1'b1;
                upd_code  <= code_step;
                upd_valid <= 1'b1;
            end

            if (track_step && !freeze) begin
                upd_code  <= code_step;
                upd_valid <= 1'b1;
            end
        end
    end

endmodule
